mem_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single synchronous memory port (16-bit address, 8-bit data, separate read/write data) between the CPU core and a DMA requester. It sits between the CPU bus interface and the memory. It serialises accesses through a fixed four-state sequence and resolves contention round-robin so neither requester starves. All memory-side outputs and requester responses are registered.

---
 rtl/mem_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one synchronous memory port between the CPU core and a DMA
//   requester. Each access walks IDLE -> ACCESS -> WAIT -> ACK, so the port
//   carries at most one access every four cycles. Simultaneous requests are
//   resolved round-robin against the previous grant. All memory-side outputs
//   and requester responses are registered.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU command, held until cpu_ack
//   cpu_rdata, cpu_ack             CPU read data and one-cycle completion pulse
//   dma_req/we/addr/wdata          DMA command, held until dma_ack
//   dma_rdata, dma_ack             DMA read data and one-cycle completion pulse
//   mem_en/we/addr/wdata           memory strobe and command (valid with mem_en)
//   mem_rdata                      memory read data, valid the cycle after mem_en
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;
  typedef enum logic {PORT_CPU, PORT_DMA} port_t;

  state_t state, state_nxt;
  port_t  owner, owner_nxt;
  port_t  last_grant, last_grant_nxt;

  logic              mem_en_nxt;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              cpu_ack_nxt;
  logic              dma_ack_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt;
  logic [DATA_W-1:0] dma_rdata_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= PORT_CPU;
      last_grant <= PORT_DMA;  // CPU wins the first tie
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      mem_en     <= mem_en_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cpu_ack    <= cpu_ack_nxt;
      dma_ack    <= dma_ack_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      dma_rdata  <= dma_rdata_nxt;
    end
  end

  // Outputs are registered, so this block computes the value each output
  // register takes for the cycle after the current state.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    mem_en_nxt     = 1'b0;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    cpu_ack_nxt    = 1'b0;
    dma_ack_nxt    = 1'b0;
    cpu_rdata_nxt  = cpu_rdata;
    dma_rdata_nxt  = dma_rdata;

    case (state)
      S_IDLE: begin
        if (cpu_req && (!dma_req || last_grant == PORT_DMA)) begin
          owner_nxt      = PORT_CPU;
          last_grant_nxt = PORT_CPU;
          mem_en_nxt     = 1'b1;
          mem_we_nxt     = cpu_we;
          mem_addr_nxt   = cpu_addr;
          mem_wdata_nxt  = cpu_wdata;
          state_nxt      = S_ACCESS;
        end else if (dma_req) begin
          owner_nxt      = PORT_DMA;
          last_grant_nxt = PORT_DMA;
          mem_en_nxt     = 1'b1;
          mem_we_nxt     = dma_we;
          mem_addr_nxt   = dma_addr;
          mem_wdata_nxt  = dma_wdata;
          state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_WAIT;
      S_WAIT: begin
        // mem_rdata is valid now; capture it together with raising ack so
        // both appear in the ACK cycle.
        if (!mem_we) begin
          if (owner == PORT_CPU) cpu_rdata_nxt = mem_rdata;
          else                   dma_rdata_nxt = mem_rdata;
        end
        cpu_ack_nxt = (owner == PORT_CPU);
        dma_ack_nxt = (owner == PORT_DMA);
        state_nxt   = S_ACK;
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts
// each grant from the round-robin rule and four-cycle slot timing, and queues
// the expected memory strobe and ack; a monitor compares every cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        cpu_ack, dma_ack, mem_en, mem_we;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  // Memory contents: physical array behind the DUT and the model's own copy.
  logic [7:0] phys_mem[int];
  logic [7:0] ref_mem[int];

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] phys_rd(input logic [15:0] a);
    if (phys_mem.exists(int'(a))) return phys_mem[int'(a)];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) phys_mem[int'(mem_addr)] = mem_wdata;
      else        mem_rdata <= phys_rd(mem_addr);
    end
  end

  // Reference model: the arbiter is free to sample at next_sample; a grant
  // occupies four cycles, strobes memory one cycle later, acks three later.
  typedef struct {
    bit          is_ack;
    int          cyc;
    bit          port;   // 0 = CPU, 1 = DMA
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  int   next_sample = 0;
  bit   last_dma = 1'b1;

  always @(posedge clk) begin
    cnt++;
    if (rst) begin
      exp_q.delete();
      last_dma    = 1'b1;
      next_sample = cnt + 1;
    end else if (cnt >= next_sample) begin
      int          g;
      exp_t        m, a;
      g = -1;
      if (cpu_req && (!dma_req || last_dma)) g = 0;
      else if (dma_req) g = 1;
      if (g < 0) begin
        next_sample = cnt + 1;
      end else begin
        m.is_ack = 1'b0;
        m.cyc    = cnt;
        m.port   = (g == 1);
        m.we     = (g == 0) ? cpu_we : dma_we;
        m.addr   = (g == 0) ? cpu_addr : dma_addr;
        m.data   = (g == 0) ? cpu_wdata : dma_wdata;
        a        = m;
        a.is_ack = 1'b1;
        a.cyc    = cnt + 2;
        if (m.we) begin
          ref_mem[int'(m.addr)] = m.data;
        end else begin
          a.data = ref_rd(m.addr);
        end
        exp_q.push_back(m);
        exp_q.push_back(a);
        last_dma    = (g == 1);
        next_sample = cnt + 4;
      end
    end
  end

  // Monitor: samples 1 time unit after each rising edge.
  logic [7:0] hold_cpu = 8'h00;
  logic [7:0] hold_dma = 8'h00;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("reset_outputs",
          64'({mem_en, mem_we, cpu_ack, dma_ack, mem_addr, mem_wdata, cpu_rdata, dma_rdata}),
          64'd0);
      hold_cpu = 8'h00;
      hold_dma = 8'h00;
    end else begin
      bit seen_mem, seen_ack;
      exp_t e;
      seen_mem = 1'b0;
      seen_ack = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cnt) begin
        e = exp_q.pop_front();
        if (e.cyc < cnt) begin
          chk("event_missed_cycle", 64'(e.cyc), 64'(cnt));
        end else if (!e.is_ack) begin
          seen_mem = 1'b1;
          chk("mem_en", 64'(mem_en), 64'd1);
          chk("mem_we", 64'(mem_we), 64'(e.we));
          chk("mem_addr", 64'(mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.data));
        end else begin
          seen_ack = 1'b1;
          chk("cpu_ack", 64'(cpu_ack), 64'(e.port == 1'b0));
          chk("dma_ack", 64'(dma_ack), 64'(e.port == 1'b1));
          if (!e.we) begin
            if (e.port) hold_dma = e.data;
            else        hold_cpu = e.data;
          end
        end
      end
      if (!seen_mem) chk("mem_en_idle", 64'(mem_en), 64'd0);
      if (!seen_ack) chk("ack_idle", 64'({cpu_ack, dma_ack}), 64'd0);
      chk("cpu_rdata", 64'(cpu_rdata), 64'(hold_cpu));
      chk("dma_rdata", 64'(dma_rdata), 64'(hold_dma));
    end
  end

  // Stimulus
  bit pend[2];

  task automatic set_cmd(input int p, input logic req, input logic we,
                         input logic [15:0] addr, input logic [7:0] wd);
    if (p == 0) begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end else begin
      dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end
  endtask

  task automatic wait_ack(input int p);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? cpu_ack : dma_ack;
    end
    chk("ack_arrived", 64'(got), 64'd1);
  endtask

  task automatic wait_mem_en();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = mem_en;
    end
    chk("mem_en_arrived", 64'(got), 64'd1);
  endtask

  task automatic drive_port(input int p, input int req_pct, input int ab_pct);
    logic ack;
    ack = (p == 0) ? cpu_ack : dma_ack;
    if (ack) pend[p] = 1'b0;
    if (pend[p]) begin
      if (int'($urandom_range(0, 99)) < ab_pct) begin
        pend[p] = 1'b0;
        if (p == 0) cpu_req = 1'b0; else dma_req = 1'b0;
      end
    end else if (int'($urandom_range(0, 99)) < req_pct) begin
      logic [15:0] a;
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      set_cmd(p, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom));
      pend[p] = 1'b1;
    end else begin
      if (p == 0) cpu_req = 1'b0; else dma_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_cmd(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_cmd(1, 1'b0, 1'b0, 16'h0000, 8'h00);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    phys_mem[int'(16'h1234)] = 8'h5A;
    ref_mem[int'(16'h1234)]  = 8'h5A;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // CPU read of 0x1234 returning 0x5A
    set_cmd(0, 1'b1, 1'b0, 16'h1234, 8'h00);
    wait_ack(0);
    cpu_req = 1'b0;

    // DMA write 0xC3 to 0xFFF0
    set_cmd(1, 1'b1, 1'b1, 16'hFFF0, 8'hC3);
    wait_ack(1);
    dma_req = 1'b0;

    // Reset for two cycles in the middle of a CPU access, request held
    set_cmd(0, 1'b1, 1'b0, 16'h0042, 8'h00);
    wait_mem_en();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(0);
    cpu_req = 1'b0;

    // Contention from reset: both requesters held high for 16 cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive_port(0, 100, 0);
      drive_port(1, 100, 0);
      @(negedge clk);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (6) @(negedge clk);

    // DMA request pulsed for one cycle while the CPU access is in ACCESS
    set_cmd(0, 1'b1, 1'b0, 16'h0077, 8'h00);
    wait_mem_en();
    set_cmd(1, 1'b1, 1'b0, 16'h0300, 8'h00);
    @(negedge clk);
    dma_req = 1'b0;
    wait_ack(0);
    cpu_req = 1'b0;

    // Back-to-back CPU reads, request held across the ack
    set_cmd(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    wait_ack(0);
    cpu_addr = 16'h0011;
    wait_ack(0);
    cpu_req = 1'b0;

    // Random traffic with occasional abandoned requests and resets
    for (int i = 0; i < 800; i++) begin
      drive_port(0, 30, 4);
      drive_port(1, 30, 4);
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      @(negedge clk);
    end

    rst = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (8) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
